// File: rtl/subbytes_iter.sv
// AES SubBytes over 16/LANES cycles with LANES forward/inverse S-box pairs; out_valid NUM_STEPS cycles after accept.
// The result is held in DONE until out_ready; in_ready follows out_ready there so blocks can run back-to-back.
module subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / LANES;
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_work;
  logic         r_inv;
  logic [127:0] w_work_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  // Byte k sits at bit offset (15-k)*8, which for a 4-bit k is {~k, 3'b000}.
  always_comb begin
    logic [6:0] w_off;
    logic [7:0] w_byte;
    w_work_nxt = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_off  = {~4'(int'(r_cnt) * LANES + l), 3'b000};
      w_byte = r_work[w_off +: 8];
      w_work_nxt[w_off +: 8] = r_inv ? sbox_inv(w_byte) : sbox_fwd(w_byte);
    end
  end

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_inv     <= 1'b0;
      state_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= state_in;
            r_inv   <= inv_in;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_work <= w_work_nxt;
          if (r_cnt == LAST_STEP) begin
            state_out <= w_work_nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            r_cnt     <= '0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              r_work  <= state_in;
              r_inv   <= inv_in;
              r_cnt   <= '0;
              busy    <= 1'b1;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_iter.sv
// Scoreboarded bench for subbytes_iter: LANES=4 main instance plus LANES 1/2/8/16 instances.
module tb_subbytes_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         inv_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] state_out;

  always #5 clk = ~clk;

  subbytes_iter #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  logic         x_clear = 1'b0;
  logic         x_in_valid = 1'b0;
  logic         x_inv = 1'b0;
  logic [127:0] x_state_in = '0;
  logic         x_in_ready [4];
  logic         x_out_valid [4];
  logic         x_busy [4];
  logic [127:0] x_state_out [4];
  int           xl [4] = '{1, 2, 8, 16};

  for (genvar g = 0; g < 4; g++) begin : g_x
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    subbytes_iter #(.LANES(L)) u_x (
      .clk(clk), .rst_n(rst_n), .clear(x_clear), .in_valid(x_in_valid), .in_ready(x_in_ready[g]),
      .state_in(x_state_in), .inv_in(x_inv), .out_valid(x_out_valid[g]), .out_ready(1'b1),
      .state_out(x_state_out[g]), .busy(x_busy[g])
    );
  end

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic         prev_ov = 1'b0;
  logic [127:0] held = '0;
  bit           rnd_ready = 1'b0;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    check(nm, 128'(act), 128'(expv));
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  // Inverse found by exhaustive search, affine map applied bit by bit.
  task automatic build_tables();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i + 4) % 8] ^ iv[(i + 5) % 8] ^ iv[(i + 6) % 8] ^ iv[(i + 7) % 8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127 - 8 * i -: 8] = inv ? isb[d[127 - 8 * i -: 8]] : sb[d[127 - 8 * i -: 8]];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk1("spurious_out_valid", 1'b1, 1'b0);
        else check("latency", 128'(cyc - acc_q[0]), 128'(4));
        held = state_out;
      end
      if (out_valid && prev_ov) check("held_stable", state_out, held);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("result", state_out, exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] expv);
    int n = 0;
    in_valid = 1'b1;
    state_in = d;
    inv_in   = inv;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (in_ready) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
    end else begin
      chk1("accept_timeout", 1'b0, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inv_in   = 1'($urandom);
    state_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic zero_test(input logic v);
    int a;
    int lat [4] = '{-1, -1, -1, -1};
    x_state_in = '0;
    x_inv      = v;
    x_in_valid = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk1("x_ready_idle", x_in_ready[g], 1'b1);
    @(posedge clk);
    #1;
    a = cyc;
    x_in_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++)
        if (x_out_valid[g] && lat[g] < 0) begin
          lat[g] = cyc - a;
          check("x_zero_result", x_state_out[g], v ? {16{8'h52}} : {16{8'h63}});
        end
    end
    for (int g = 0; g < 4; g++) check("x_zero_latency", 128'(lat[g]), 128'(16 / xl[g]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [127:0] a_d, b_d, d;
    logic         va, vb, v;
    int           n, a;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    check("rst_state_out", state_out, '0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230);
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    send('0, 1'b0, {16{8'h63}});
    send('0, 1'b1, {16{8'h52}});
    wait_drain();

    out_ready = 1'b0;
    a_d = {$urandom, $urandom, $urandom, $urandom};
    va  = 1'($urandom);
    b_d = {$urandom, $urandom, $urandom, $urandom};
    vb  = 1'($urandom);
    send(a_d, va, model(a_d, va));
    state_in = b_d;
    inv_in   = vb;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_busy", busy, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("b2b_in_ready", in_ready, 1'b1);
    exp_q.push_back(model(b_d, vb));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_out_valid", out_valid, 1'b0);
    wait_drain();

    rnd_ready = 1'b1;
    repeat (40) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      v = 1'($urandom);
      n = $urandom_range(0, 2);
      if (n != 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
      send(d, v, model(d, v));
    end
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    zero_test(1'b0);
    zero_test(1'b1);

    x_clear    = 1'b1;
    x_in_valid = 1'b1;
    @(posedge clk);
    #1;
    x_clear    = 1'b0;
    x_in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk1("clear_blocks_accept", x_busy[g], 1'b0);
    @(posedge clk);
    #1;

    x_state_in = {$urandom, $urandom, $urandom, $urandom};
    x_inv      = 1'($urandom);
    x_in_valid = 1'b1;
    @(posedge clk);
    #1;
    x_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    x_clear = 1'b1;
    @(posedge clk);
    #1;
    x_clear = 1'b0;
    @(negedge clk);
    chk1("clear_idle_ready", x_in_ready[1], 1'b1);
    chk1("clear_idle_busy", x_busy[1], 1'b0);
    repeat (12) begin
      chk1("clear_no_out_valid", x_out_valid[1], 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    d = {$urandom, $urandom, $urandom, $urandom};
    v = 1'($urandom);
    x_state_in = d;
    x_inv      = v;
    x_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    x_in_valid = 1'b0;
    n = 0;
    while (!x_out_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("after_clear_latency", 128'(cyc - a), 128'(8));
    check("after_clear_result", x_state_out[1], model(d, v));

    @(posedge clk);
    #1;
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk1("pre_reset_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk1("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk1("async_out_valid", out_valid, 1'b0);
    chk1("async_busy", busy, 1'b0);
    check("async_state_out", state_out, '0);
    chk1("async_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_reset_in_ready", in_ready, 1'b1);
    chk1("post_reset_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subbytes_iter.md
Name: subbytes_iter

Overview:
- Sequential, parametrised SubBytes engine for the AES-128 datapath.
- Takes a 128-bit state over a valid/ready handshake and substitutes its bytes through LANES S-box instances, over 16/LANES cycles.
- A per-block mode bit selects the forward S-box (encrypt) or the inverse S-box (decrypt).
- Sits between ShiftRows/AddRoundKey stages in iterative cipher and inverse-cipher round logic, where area is traded against latency.

Parameters:
- LANES, 4, number of S-box lanes used per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NUM_STEPS, 16/LANES, derived, not overridable: cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  state_in and inv_in are valid
- in_ready  output  1  block can accept a new state
- state_in  input  128  state to substitute; byte 0 = bits [127:120], byte 15 = bits [7:0]
- inv_in  input  1  0 = forward S-box, 1 = inverse S-box
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts the result
- state_out  output  128  substituted state, same byte order as state_in
- busy  output  1  high while in BUSY

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; step counter, working register and state_out go to 0.
  - out_valid=0, busy=0, latched mode=0.
  - in_ready=1, since it is decoded from IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, at the clock edge: latch state_in into the working register, latch inv_in, counter=0, go to BUSY.
- BUSY:
  - busy=1, in_ready=0.
  - Each cycle, bytes counter*LANES through counter*LANES+LANES-1 of the working register are replaced by S(byte), or by InvS(byte) when the latched mode is 1. The counter then increments.
  - When counter reaches NUM_STEPS-1, the final substitution is written, state_out is loaded with the completed working register, and the FSM goes to DONE.
- Latency:
  - If the accept edge is cycle k, out_valid is first high after edge k+NUM_STEPS.
  - Examples: LANES=16 gives 1 cycle; LANES=4 gives 4; LANES=1 gives 16.
- DONE:
  - out_valid=1; state_out is held stable until out_ready=1.
  - in_ready = out_ready, which allows back-to-back blocks.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid drops next cycle.
  - out_ready=1 and in_valid=1: the result is consumed and the new block is accepted at the same edge; go to BUSY, out_valid drops next cycle.
  - out_ready=0: stay in DONE; in_valid is ignored.
- Steady-state throughput is one block per NUM_STEPS+1 cycles.
- clear:
  - Has priority over every transition. At the next edge: go to IDLE, out_valid=0, counter=0.
  - state_out is not cleared. Any pending result or partially substituted block is discarded.
  - clear and in_valid high together: the input is not accepted.
- Mode is sampled only at acceptance. Changing inv_in mid-block has no effect.
- state_out changes only on entry to DONE (or reset). It is never updated with partial results.
- S-box tables:
  - Forward: the FIPS-197 S-box.
  - Inverse: the FIPS-197 InvS-box.
  - Both are purely combinational, one pair per lane, with full 256-entry coverage. The result is never X for a known input.

Test Plan:
- FIPS-197 forward vector, LANES=4, inv_in=0:
  - Stimulus: state_in = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: state_out = d42711aee0bf98f1b8b45de51e415230; out_valid exactly 4 cycles after the accept edge.
- Inverse round-trip:
  - Stimulus: state_in = d42711aee0bf98f1b8b45de51e415230, inv_in=1.
  - Required: state_out = 193de3bea0f4e22b9ac68d2ae9f84808.
- All-zero state, for each LANES value 1, 2, 4, 8 and 16:
  - Forward: state_out = 16 bytes of 63.
  - Inverse: state_out = 16 bytes of 52.
  - Latency must equal 16/LANES in every case.
- Backpressure and back-to-back:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1.
  - Required: state_out stable, in_ready=0, no accept. Then raise out_ready with in_valid=1: result and new block hand off at the same edge, FSM in BUSY next cycle.
- clear mid-operation:
  - Stimulus: pulse clear at counter=2 (LANES=2).
  - Required: IDLE next cycle, out_valid never asserts for that block; the next block produces a correct result.
- Async reset mid-BUSY:
  - Stimulus: drop rst_n between clock edges.
  - Required: out_valid=0, busy=0 and state_out=0 immediately, without a clock edge; in_ready=1 after release.
